sram_1r1w_init: RTL and testbench

// - Parametrised behavioural 1R1W SRAM; successor to the fixed-geometry single-port RW0 arrays.
// - Separate read/write ports, configurable read latency, per-granule write mask.
// - Hardware zero-initialisation after reset; no randomised state, so simulation is deterministic.
// - Used for cache data/tag arrays and queue storage in the LiteX Rocket subsystem.

---
 rtl/sram_1r1w_init_pkg.sv | 16 +
 rtl/sram_1r1w_init_if.sv | 22 ++
 rtl/sram_1r1w_init_rd_pipe.sv | 30 +++
 rtl/sram_1r1w_init.sv | 81 ++++++++
 tb/tb_sram_1r1w_init.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/sram_1r1w_init_pkg.sv
// sram_pkg: shared state type, geometry helpers and parameter legality checks for sram_1r1w_init.
package sram_pkg;
   typedef enum logic {ST_INIT, ST_RUN} sram_state_t;
   function automatic int addr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction
   function automatic int mask_w(input int width, input int gran);
      return width / gran;
   endfunction
   function automatic bit gran_ok(input int width, input int gran);
      return (gran > 0) && (width % gran == 0);
   endfunction
   function automatic bit lat_ok(input int lat);
      return (lat == 1) || (lat == 2);
   endfunction
endpackage

// File: rtl/sram_1r1w_init_if.sv
// sram_1r1w_init_if: write port, read port and ready status of the 1R1W SRAM.
interface sram_1r1w_init_if #(
   parameter int DEPTH     = 1024,
   parameter int WIDTH     = 128,
   parameter int MASK_GRAN = 8
);
   localparam int ADDR_W = sram_pkg::addr_w(DEPTH);
   localparam int MASK_W = sram_pkg::mask_w(WIDTH, MASK_GRAN);
   logic              ready;
   logic              W0_en;
   logic [ADDR_W-1:0] W0_addr;
   logic [MASK_W-1:0] W0_mask;
   logic [WIDTH-1:0]  W0_data;
   logic              R0_en;
   logic [ADDR_W-1:0] R0_addr;
   logic              R0_valid;
   logic [WIDTH-1:0]  R0_data;
   modport master (output W0_en, W0_addr, W0_mask, W0_data, R0_en, R0_addr,
                   input  ready, R0_valid, R0_data);
   modport slave  (input  W0_en, W0_addr, W0_mask, W0_data, R0_en, R0_addr,
                   output ready, R0_valid, R0_data);
endinterface

// File: rtl/sram_1r1w_init_rd_pipe.sv
// sram_rd_pipe: read-result valid/data shift stages; each data stage holds while no valid passes through.
module sram_rd_pipe #(
   parameter int WIDTH        = 128,
   parameter int READ_LATENCY = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             valid_i,
   input  logic [WIDTH-1:0] data_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o
);
   logic [READ_LATENCY-1:0] valid_q;
   logic [WIDTH-1:0]        data_q [READ_LATENCY];
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         valid_q <= '0;
         for (int i = 0; i < READ_LATENCY; i++) data_q[i] <= '0;
      end else begin
         valid_q[0] <= valid_i;
         if (valid_i) data_q[0] <= data_i;
         for (int i = 1; i < READ_LATENCY; i++) begin
            valid_q[i] <= valid_q[i-1];
            if (valid_q[i-1]) data_q[i] <= data_q[i-1];
         end
      end
   end
   assign valid_o = valid_q[READ_LATENCY-1];
   assign data_o  = data_q[READ_LATENCY-1];
endmodule

// File: rtl/sram_1r1w_init.sv
// sram_1r1w_init: 1R1W SRAM with hardware zero-init after reset, granule write mask, read latency 1 or 2.
// Macro SRAM_FWD_EN selects write-first same-address reads; undefined gives read-first.
module sram_1r1w_init
   import sram_pkg::*;
#(
   parameter int DEPTH        = 1024,
   parameter int WIDTH        = 128,
   parameter int MASK_GRAN    = 8,
   parameter int READ_LATENCY = 1
) (
   input logic             clock,
   input logic             reset,
   sram_1r1w_init_if.slave bus
);
   localparam int ADDR_W = addr_w(DEPTH);
   localparam int MASK_W = mask_w(WIDTH, MASK_GRAN);

   if (!gran_ok(WIDTH, MASK_GRAN)) begin : g_bad_gran
      $error("sram_1r1w_init: WIDTH must be a multiple of MASK_GRAN");
   end
   if (!lat_ok(READ_LATENCY)) begin : g_bad_lat
      $error("sram_1r1w_init: READ_LATENCY must be 1 or 2");
   end

   logic [WIDTH-1:0]  ram_q [DEPTH];
   sram_state_t       state_q, state_d;
   logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
   logic              ready_q, ready_d;
   logic              init_last, w_hit, r_acc, r_in;
   logic [WIDTH-1:0]  w_bits, w_word, r_old, r_word;

   for (genvar g = 0; g < MASK_W; g++) begin : g_mask
      assign w_bits[g*MASK_GRAN +: MASK_GRAN] = {MASK_GRAN{bus.W0_mask[g]}};
   end

   always_comb begin
      init_last  = (state_q == ST_INIT) && (init_cnt_q == ADDR_W'(DEPTH - 1));
      state_d    = init_last ? ST_RUN : state_q;
      ready_d    = ready_q | init_last;
      init_cnt_d = (state_q == ST_INIT) ? init_cnt_q + 1'b1 : init_cnt_q;
      w_hit      = ready_q && bus.W0_en && (32'(bus.W0_addr) < DEPTH);
      r_acc      = ready_q && bus.R0_en;
      r_in       = 32'(bus.R0_addr) < DEPTH;
      w_word     = (ram_q[bus.W0_addr] & ~w_bits) | (bus.W0_data & w_bits);
      r_old      = r_in ? ram_q[bus.R0_addr] : '0;
`ifdef SRAM_FWD_EN
      r_word     = (w_hit && bus.W0_addr == bus.R0_addr) ? (r_old & ~w_bits) | (bus.W0_data & w_bits) : r_old;
`else
      r_word     = r_old;
`endif
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= ST_INIT;
         init_cnt_q <= '0;
         ready_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
         ready_q    <= ready_d;
      end
   end

   // Storage is not reset; the INIT sweep clears it once reset is released.
   always_ff @(posedge clock) begin
      if (state_q == ST_INIT) ram_q[init_cnt_q] <= '0;
      else if (w_hit) ram_q[bus.W0_addr] <= w_word;
   end

   assign bus.ready = ready_q;

   sram_rd_pipe #(.WIDTH(WIDTH), .READ_LATENCY(READ_LATENCY)) u_rd_pipe (
      .clock   (clock),
      .reset   (reset),
      .valid_i (r_acc),
      .data_i  (r_word),
      .valid_o (bus.R0_valid),
      .data_o  (bus.R0_data)
   );
endmodule

// File: tb/tb_sram_1r1w_init.sv
// tb_sram_1r1w_init: two SRAMs (DEPTH 16 / latency 1 and DEPTH 12 / latency 2) on shared stimulus,
// checked each cycle against an array model plus literal expectations.
module tb_sram_1r1w_init;
   localparam int DEP [2] = '{16, 12};
   localparam int LAT [2] = '{1, 2};

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        go = 1'b0;
   logic        w_en = 1'b0, r_en = 1'b0;
   logic [3:0]  w_addr = '0, r_addr = '0, w_mask = '0;
   logic [31:0] w_data = '0;
   int          vecs = 0, errs = 0;

   always #5 clock = ~clock;

   sram_1r1w_init_if #(.DEPTH(16), .WIDTH(32), .MASK_GRAN(8)) if0 ();
   sram_1r1w_init_if #(.DEPTH(12), .WIDTH(32), .MASK_GRAN(8)) if1 ();

   assign if0.W0_en = w_en;   assign if1.W0_en = w_en;
   assign if0.W0_addr = w_addr; assign if1.W0_addr = w_addr;
   assign if0.W0_mask = w_mask; assign if1.W0_mask = w_mask;
   assign if0.W0_data = w_data; assign if1.W0_data = w_data;
   assign if0.R0_en = r_en;   assign if1.R0_en = r_en;
   assign if0.R0_addr = r_addr; assign if1.R0_addr = r_addr;

   sram_1r1w_init #(.DEPTH(16), .WIDTH(32), .MASK_GRAN(8), .READ_LATENCY(1)) u0 (
      .clock(clock), .reset(reset), .bus(if0));
   sram_1r1w_init #(.DEPTH(12), .WIDTH(32), .MASK_GRAN(8), .READ_LATENCY(2)) u1 (
      .clock(clock), .reset(reset), .bus(if1));

   logic        rdy_a [2];
   logic        v_a [2];
   logic [31:0] d_a [2];
   assign rdy_a[0] = if0.ready;    assign rdy_a[1] = if1.ready;
   assign v_a[0]   = if0.R0_valid; assign v_a[1]   = if1.R0_valid;
   assign d_a[0]   = if0.R0_data;  assign d_a[1]   = if1.R0_data;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] m);
      merge = o;
      for (int g = 0; g < 4; g++) if (m[g]) merge[g*8 +: 8] = n[g*8 +: 8];
   endfunction

   // Model: reset zeroes every word; a DUT is busy for DEP posedges after reset, then serves
   // accesses. Each read result is scheduled for the posedge it becomes visible.
   logic [31:0] mem [2][16];
   int          k [2];
   int          cyc;
   logic        sv [2][4];
   int          sdue [2][4];
   logic [31:0] sd [2][4];
   logic [31:0] last_d [2];

   always @(posedge clock or posedge reset) begin : model
      logic [31:0] rv;
      int s;
      if (reset) begin
         cyc = 0;
         for (int d = 0; d < 2; d++) begin
            k[d] = 0;
            for (int j = 0; j < 4; j++) sv[d][j] = 1'b0;
            for (int a = 0; a < 16; a++) mem[d][a] = '0;
         end
      end else begin
         cyc++;
         for (int d = 0; d < 2; d++) begin
            if (k[d] < DEP[d]) k[d]++;
            else begin
               if (r_en) begin
                  rv = (int'(r_addr) < DEP[d]) ? mem[d][r_addr] : 32'h0;
`ifdef SRAM_FWD_EN
                  if (w_en && w_addr == r_addr && int'(w_addr) < DEP[d]) rv = merge(rv, w_data, w_mask);
`endif
                  s = (cyc + LAT[d] - 1) % 4;
                  sv[d][s] = 1'b1;
                  sdue[d][s] = cyc + LAT[d] - 1;
                  sd[d][s] = rv;
               end
               if (w_en && int'(w_addr) < DEP[d]) mem[d][w_addr] = merge(mem[d][w_addr], w_data, w_mask);
            end
         end
      end
   end

   always @(negedge clock) begin : compare
      logic ev;
      int s;
      if (go) begin
         for (int d = 0; d < 2; d++) begin
            s = cyc % 4;
            ev = !reset && sv[d][s] && sdue[d][s] == cyc;
            if (reset) last_d[d] = '0;
            else if (ev) last_d[d] = sd[d][s];
            chk($sformatf("d%0d ready c%0d", d, cyc), 32'(rdy_a[d]), 32'(k[d] >= DEP[d]));
            chk($sformatf("d%0d valid c%0d", d, cyc), 32'(v_a[d]), 32'(ev));
            chk($sformatf("d%0d data c%0d", d, cyc), d_a[d], last_d[d]);
         end
      end
   end

   task automatic tick();
      @(negedge clock);
   endtask
   task automatic idle();
      w_en = 1'b0; r_en = 1'b0;
   endtask
   task automatic wr(input logic [3:0] a, input logic [3:0] m, input logic [31:0] dat);
      w_en = 1'b1; w_addr = a; w_mask = m; w_data = dat;
   endtask
   task automatic rd(input logic [3:0] a);
      r_en = 1'b1; r_addr = a;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin : stim
      int n, n1;
      #1 reset = 1'b1; go = 1'b1;
      tick(); tick(); #2 reset = 1'b0;
      n = 0; n1 = 0;
      while (!rdy_a[0] && n < 40) begin
         tick(); n++;
         if (rdy_a[1] && n1 == 0) n1 = n;
      end
      chk("init length d0", n, 16);
      chk("init length d1", n1, 12);

      for (int a = 0; a < 16; a++) begin rd(4'(a)); tick(); end
      idle(); tick(); tick();

      wr(4'd3, 4'hF, 32'hA5A5A5A5); tick();
      idle(); rd(4'd3); tick();
      chk("lat1 valid d0", 32'(v_a[0]), 1);
      chk("lat2 not yet d1", 32'(v_a[1]), 0);
      chk("lat1 data d0", d_a[0], 32'hA5A5A5A5);
      idle(); tick();
      chk("lat2 valid d1", 32'(v_a[1]), 1);
      chk("lat2 data d1", d_a[1], 32'hA5A5A5A5);
      chk("lat1 pulse d0", 32'(v_a[0]), 0);

      wr(4'd7, 4'hF, 32'h11223344); tick();
      wr(4'd7, 4'b0101, 32'hFFFFFFFF); tick();
      idle(); rd(4'd7); tick();
      idle(); tick();
      chk("partial mask d0", d_a[0], 32'h11FF33FF);
      chk("partial mask d1", d_a[1], 32'h11FF33FF);

      wr(4'd5, 4'hF, 32'hDEADBEEF); rd(4'd5); tick();
`ifdef SRAM_FWD_EN
      chk("same-cycle rw d0", d_a[0], 32'hDEADBEEF);
`else
      chk("same-cycle rw d0", d_a[0], 32'h0);
`endif
      idle(); rd(4'd5); tick();
      chk("read after write d0", d_a[0], 32'hDEADBEEF);
      idle(); tick(); tick();

      wr(4'd14, 4'hF, 32'h12345678); tick();
      idle(); rd(4'd13); tick();
      idle(); tick();
      chk("oor read valid d1", 32'(v_a[1]), 1);
      chk("oor read data d1", d_a[1], 32'h0);
      rd(4'd3); tick(); rd(4'd2); tick(); idle(); tick();
      chk("oor write no alias d1", d_a[1], 32'h0);
      for (int a = 0; a < 16; a++) begin rd(4'(a)); tick(); end
      idle(); tick(); tick();

      #2 reset = 1'b1; tick(); tick(); #2 reset = 1'b0;
      repeat (7) tick();
      chk("ready mid-init d0", 32'(rdy_a[0]), 0);
      #2 reset = 1'b1; tick(); tick(); #2 reset = 1'b0;
      n = 0;
      while (!rdy_a[0] && n < 40) begin
         tick(); n++;
         if (n == 3) wr(4'd2, 4'hF, 32'hFFFFFFFF);
         if (n == 4) idle();
      end
      chk("restart length d0", n, 16);
      rd(4'd2); tick();
      chk("init write lost d0", d_a[0], 32'h0);
      rd(4'd3); tick();
      chk("reinit clears d0", d_a[0], 32'h0);
      idle(); tick(); tick();
      for (int a = 0; a < 16; a++) begin rd(4'(a)); tick(); end
      idle(); tick(); tick();

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
